// File: rtl/uneander_control.sv
// uneander_control: one-hot T0..T7 sequencer decoding the UNEANDER instruction set into datapath strobes.
module uneander_control (
    input  logic       ck,
    input  logic       nreset,
    input  logic [3:0] op,
    input  logic       n,
    input  logic       z,
    output logic [7:0] t,
    output logic       carga_rem,
    output logic       sel_rem,
    output logic       read,
    output logic       write,
    output logic       carga_rdm,
    output logic       inc_pc,
    output logic       carga_pc,
    output logic       carga_ri,
    output logic       carga_ac,
    output logic       carga_nz,
    output logic [2:0] sel_ula,
    output logic       halt
);
    typedef enum logic [7:0] {
        T0 = 8'h01, T1 = 8'h02, T2 = 8'h04, T3 = 8'h08,
        T4 = 8'h10, T5 = 8'h20, T6 = 8'h40, T7 = 8'h80
    } state_t;

    state_t state, next;
    logic rem_d, srem_d, rd_d, wr_d, rdm_d, inc_d, pc_d, ri_d, ac_d, nz_d, halt_d;
    logic [2:0] ula_d;
    logic mem_op, is_sta, is_not, is_hlt, jump_taken, jump_skip;

    assign mem_op     = (op >= 4'h1) && (op <= 4'h5);
    assign is_sta     = op == 4'h1;
    assign is_not     = op == 4'h6;
    assign is_hlt     = op == 4'hF;
    assign jump_taken = (op == 4'h8) || (op == 4'h9 && n) || (op == 4'hA && z);
    assign jump_skip  = (op == 4'h9 && !n) || (op == 4'hA && !z);

    always_ff @(posedge ck or negedge nreset) begin
        if (!nreset) state <= T0;
        else         state <= next;
    end

    always_comb begin
        next   = T0;
        rem_d  = 1'b0;
        srem_d = 1'b0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        rdm_d  = 1'b0;
        inc_d  = 1'b0;
        pc_d   = 1'b0;
        ri_d   = 1'b0;
        ac_d   = 1'b0;
        nz_d   = 1'b0;
        halt_d = 1'b0;
        ula_d  = 3'b000;
        case (state)
            T0: begin
                rem_d = 1'b1;
                next  = T1;
            end
            T1: begin
                rd_d  = 1'b1;
                inc_d = 1'b1;
                next  = T2;
            end
            T2: begin
                ri_d = 1'b1;
                next = T3;
            end
            T3: begin
                if (is_hlt) begin
                    halt_d = 1'b1;
                    next   = T3;
                end else if (is_not) begin
                    ac_d  = 1'b1;
                    nz_d  = 1'b1;
                    ula_d = 3'b011;
                end else if (jump_skip) begin
                    inc_d = 1'b1;
                end else if (mem_op || jump_taken) begin
                    rem_d = 1'b1;
                    next  = T4;
                end
            end
            T4: begin
                rd_d  = 1'b1;
                inc_d = 1'b1;
                next  = T5;
            end
            T5: begin
                if (jump_taken) begin
                    pc_d = 1'b1;
                end else if (mem_op) begin
                    rem_d  = 1'b1;
                    srem_d = 1'b1;
                    next   = T6;
                end
            end
            T6: begin
                rdm_d = is_sta;
                rd_d  = !is_sta;
                next  = T7;
            end
            T7: begin
                wr_d  = is_sta;
                ac_d  = mem_op && !is_sta;
                nz_d  = mem_op && !is_sta;
                ula_d = op == 4'h2 ? 3'b100 :
                        op == 4'h4 ? 3'b010 :
                        op == 4'h5 ? 3'b001 : 3'b000;
            end
            default: next = T0;
        endcase
    end

    // Reset gates every strobe combinationally so nothing fires while nreset is low.
    assign t         = state;
    assign carga_rem = nreset & rem_d;
    assign sel_rem   = nreset & srem_d;
    assign read      = nreset & rd_d;
    assign write     = nreset & wr_d;
    assign carga_rdm = nreset & rdm_d;
    assign inc_pc    = nreset & inc_d;
    assign carga_pc  = nreset & pc_d;
    assign carga_ri  = nreset & ri_d;
    assign carga_ac  = nreset & ac_d;
    assign carga_nz  = nreset & nz_d;
    assign halt      = nreset & halt_d;
    assign sel_ula   = nreset ? ula_d : 3'b000;
endmodule

// File: tb/tb_uneander_control.sv
// tb_uneander_control: directed per-cycle checks of the control sequencer against hand-built vectors.
module tb_uneander_control;
    logic ck, nreset, n, z;
    logic [3:0] op;
    logic [7:0] t;
    logic carga_rem, sel_rem, read, write, carga_rdm, inc_pc, carga_pc, carga_ri, carga_ac, carga_nz, halt;
    logic [2:0] sel_ula;
    logic [21:0] obs;
    int total = 0;
    int bad = 0;

    localparam logic [21:0] HALT = 22'h1;
    localparam logic [21:0] SU_AND = 22'h1 << 1;
    localparam logic [21:0] SU_OR  = 22'h2 << 1;
    localparam logic [21:0] SU_NOT = 22'h3 << 1;
    localparam logic [21:0] SU_LDA = 22'h4 << 1;
    localparam logic [21:0] NZ  = 22'h1 << 4;
    localparam logic [21:0] AC  = 22'h1 << 5;
    localparam logic [21:0] RI  = 22'h1 << 6;
    localparam logic [21:0] PC  = 22'h1 << 7;
    localparam logic [21:0] INC = 22'h1 << 8;
    localparam logic [21:0] RDM = 22'h1 << 9;
    localparam logic [21:0] WR  = 22'h1 << 10;
    localparam logic [21:0] RD  = 22'h1 << 11;
    localparam logic [21:0] SR  = 22'h1 << 12;
    localparam logic [21:0] REM = 22'h1 << 13;

    uneander_control dut (
        .ck(ck), .nreset(nreset), .op(op), .n(n), .z(z), .t(t),
        .carga_rem(carga_rem), .sel_rem(sel_rem), .read(read), .write(write),
        .carga_rdm(carga_rdm), .inc_pc(inc_pc), .carga_pc(carga_pc), .carga_ri(carga_ri),
        .carga_ac(carga_ac), .carga_nz(carga_nz), .sel_ula(sel_ula), .halt(halt)
    );

    assign obs = {t, carga_rem, sel_rem, read, write, carga_rdm, inc_pc, carga_pc,
                  carga_ri, carga_ac, carga_nz, sel_ula, halt};

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic logic [21:0] tv(input int k);
        return 22'h1 << (14 + k);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge ck) begin
        if (nreset === 1'b1) begin
            chk("mon_rd_wr", {31'b0, read & write}, 32'h0);
            chk("mon_inc_pc", {31'b0, inc_pc & carga_pc}, 32'h0);
            chk("mon_onehot", {31'b0, $onehot(t)}, 32'h1);
        end
    end

    // Fetch T0..T2 is common; the tail holds the hand-computed T3.. vectors.
    task automatic run(input string tag, input logic [3:0] o, input logic nn, input logic zz,
                       input int len, input logic [21:0] a, b, c, d, e);
        logic [21:0] s [8];
        s = '{tv(0) | REM, tv(1) | RD | INC, tv(2) | RI, a, b, c, d, e};
        for (int i = 0; i < 3 + len; i++) begin
            @(negedge ck);
            chk($sformatf("%s_c%0d", tag, i), {10'b0, obs}, {10'b0, s[i]});
            if (i == 0) begin
                op = o;
                n  = nn;
                z  = zz;
            end
        end
    endtask

    initial begin
        nreset = 1'b0;
        op = 4'h2;
        n = 1'b0;
        z = 1'b0;
        repeat (2) @(negedge ck);
        chk("reset", {10'b0, obs}, {10'b0, tv(0)});
        @(posedge ck);
        #1 nreset = 1'b1;
        run("lda", 4'h2, 0, 0, 5, tv(3) | REM, tv(4) | RD | INC, tv(5) | REM | SR, tv(6) | RD, tv(7) | AC | NZ | SU_LDA);
        run("sta", 4'h1, 0, 0, 5, tv(3) | REM, tv(4) | RD | INC, tv(5) | REM | SR, tv(6) | RDM, tv(7) | WR);
        run("add", 4'h3, 0, 0, 5, tv(3) | REM, tv(4) | RD | INC, tv(5) | REM | SR, tv(6) | RD, tv(7) | AC | NZ);
        run("or", 4'h4, 0, 0, 5, tv(3) | REM, tv(4) | RD | INC, tv(5) | REM | SR, tv(6) | RD, tv(7) | AC | NZ | SU_OR);
        run("and", 4'h5, 0, 0, 5, tv(3) | REM, tv(4) | RD | INC, tv(5) | REM | SR, tv(6) | RD, tv(7) | AC | NZ | SU_AND);
        run("jn_t", 4'h9, 1, 0, 3, tv(3) | REM, tv(4) | RD | INC, tv(5) | PC, 0, 0);
        run("jn_nt", 4'h9, 0, 1, 1, tv(3) | INC, 0, 0, 0, 0);
        run("jz_t", 4'hA, 0, 1, 3, tv(3) | REM, tv(4) | RD | INC, tv(5) | PC, 0, 0);
        run("jz_nt", 4'hA, 1, 0, 1, tv(3) | INC, 0, 0, 0, 0);
        run("jmp", 4'h8, 0, 0, 3, tv(3) | REM, tv(4) | RD | INC, tv(5) | PC, 0, 0);
        run("not", 4'h6, 0, 0, 1, tv(3) | AC | NZ | SU_NOT, 0, 0, 0, 0);
        run("op_b", 4'hB, 0, 0, 1, tv(3), 0, 0, 0, 0);
        run("nop", 4'h0, 0, 0, 1, tv(3), 0, 0, 0, 0);
        run("op_7", 4'h7, 1, 1, 1, tv(3), 0, 0, 0, 0);
        run("hlt", 4'hF, 0, 0, 1, tv(3) | HALT, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge ck);
            chk("hlt_hold", {10'b0, obs}, {10'b0, tv(3) | HALT});
        end
        @(posedge ck);
        #2 nreset = 1'b0;
        #1 chk("rst_async", {10'b0, obs}, {10'b0, tv(0)});
        #1 nreset = 1'b1;
        @(negedge ck);
        chk("rst_t0", {10'b0, obs}, {10'b0, tv(0) | REM});
        op = 4'h2;
        @(negedge ck);
        chk("rst_t1", {10'b0, obs}, {10'b0, tv(1) | RD | INC});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
